// File: rtl/kolibri_pkg.sv
// rtl/kolibri_pkg.sv - shared types and constants for the kolibri memory-mapping unit
// Contents:
//   mmuState_t       task FSM states (user task, system task, armed return to user)
//   OFF_CTRL/OFF_TASK register offsets inside the 16-byte register window
//   IO_PAGE_DEFAULT  default A[15:8] of the I/O page
//   CTRL_*           bit positions inside the CTRL register
package kolibri_pkg;

    typedef enum logic [1:0] {
        S_USER  = 2'd0,
        S_SYS   = 2'd1,
        S_ARMED = 2'd2
    } mmuState_t;

    localparam logic [3:0] OFF_CTRL        = 4'h8;
    localparam logic [3:0] OFF_TASK        = 4'h9;
    localparam logic [7:0] IO_PAGE_DEFAULT = 8'hFE;

    localparam int CTRL_MAP_EN   = 0;
    localparam int CTRL_AUTO_SYS = 1;

endpackage

// File: rtl/kolibri_mmu_regfile.sv
// rtl/kolibri_mmu_regfile.sv - page register file, one write port and two async read ports
// Ports:
//   clk, rst            clock and asynchronous active-high reset (clears all registers)
//   we, wAddr, wData    write port, sampled on the rising clock edge
//   mapAddr, mapData    combinational read port used for address mapping
//   rbAddr, rbData      combinational read port used for CPU readback
module kolibri_mmu_regfile
    import kolibri_pkg::*;
#(
    parameter int NP    = 8,
    parameter int BW    = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wAddr,
    input  logic [BW-1:0]    wData,
    input  logic [IDX_W-1:0] mapAddr,
    output logic [BW-1:0]    mapData,
    input  logic [IDX_W-1:0] rbAddr,
    output logic [BW-1:0]    rbData
);

    logic [BW-1:0] pageRegs [NP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                pageRegs[i] <= '0;
            end
        end else if (we) begin
            pageRegs[wAddr] <= wData;
        end
    end

    assign mapData = pageRegs[mapAddr];
    assign rbData  = pageRegs[rbAddr];

endmodule

// File: rtl/kolibri_mmu.sv
// rtl/kolibri_mmu.sv - 6309E memory-mapping unit with per-task page registers in the I/O page
// Ports:
//   MHZ48, RES          master clock, asynchronous active-high reset
//   E                   6309E E clock; a high->low transition is the commit point
//   A, RW, D_IN         CPU address, read/write strobe (1 = read), write data
//   D_OUT, D_OE         register readback data and bus drive enable
//   BA, BS, LIC         6309E bus status and last-instruction-cycle
//   MA, nMM             physical bank and map-mode flag (0 = map mode)
//   nSTROBE             low while an MMU register is being accessed
//   SYS                 system task active
module kolibri_mmu
    import kolibri_pkg::*;
#(
    parameter int         PAGE_BITS = 2,
    parameter int         PHYS_W    = 22,
    parameter int         TASKS     = 2,
    parameter logic [7:0] IO_PAGE   = IO_PAGE_DEFAULT,
    parameter logic [7:0] REG_BASE  = 8'h00,
    localparam int        BW        = PHYS_W - (16 - PAGE_BITS)
) (
    input  logic          MHZ48,
    input  logic          RES,
    input  logic          E,
    input  logic [15:0]   A,
    input  logic          RW,
    input  logic [7:0]    D_IN,
    output logic [7:0]    D_OUT,
    output logic          D_OE,
    input  logic          BA,
    input  logic          BS,
    input  logic          LIC,
    output logic [BW-1:0] MA,
    output logic          nMM,
    output logic          nSTROBE,
    output logic          SYS
);

    localparam int NP     = TASKS << PAGE_BITS;
    localparam int TASK_W = $clog2(TASKS);
    localparam int IDX_W  = TASK_W + PAGE_BITS;
    // Only the low byte of a page register is reachable from the 8-bit bus.
    localparam int DW     = (BW < 8) ? BW : 8;
    localparam logic [4:0] NP5 = 5'(NP);

    mmuState_t         state;
    logic              eQ;
    logic              mapEn;
    logic              autoSys;
    logic [TASK_W-1:0] userTask;

    logic              sel;
    logic              commit;
    logic              wrCommit;
    logic              pageHit;
    logic              pageWrite;
    logic              ctrlWrite;
    logic              taskWrite;
    logic              vecFetch;
    logic [3:0]        offset;
    logic [TASK_W-1:0] actTask;
    logic [BW-1:0]     mapData;
    logic [BW-1:0]     rbData;

    assign offset   = A[3:0];
    assign sel      = (A[15:8] == IO_PAGE) && (A[7:4] == REG_BASE[7:4]);
    // E is synchronous to MHZ48, so one register is enough to see its falling edge.
    assign commit   = eQ & ~E;
    assign wrCommit = commit & sel & ~RW;
    assign pageHit  = {1'b0, offset} < NP5;

    assign pageWrite = wrCommit & pageHit;
    assign ctrlWrite = wrCommit & ~pageHit & (offset == OFF_CTRL);
    assign taskWrite = wrCommit & ~pageHit & (offset == OFF_TASK);
    assign vecFetch  = commit & autoSys & BS & ~BA;

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            eQ       <= 1'b0;
            state    <= S_SYS;
            mapEn    <= 1'b0;
            autoSys  <= 1'b0;
            userTask <= '0;
        end else begin
            eQ <= E;
            if (ctrlWrite) begin
                mapEn   <= D_IN[CTRL_MAP_EN];
                autoSys <= D_IN[CTRL_AUTO_SYS];
            end
            // The task value is stored in every state, even when a vector
            // fetch wins the state transition in the same commit.
            if (taskWrite) begin
                userTask <= D_IN[TASK_W-1:0];
            end
            if (commit) begin
                case (state)
                    S_USER: begin
                        if (vecFetch) state <= S_SYS;
                    end
                    S_SYS: begin
                        if (!vecFetch && taskWrite) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (vecFetch) state <= S_SYS;
                        else if (LIC) state <= S_USER;
                    end
                    default: state <= S_SYS;
                endcase
            end
        end
    end

    assign SYS     = (state != S_USER);
    assign actTask = SYS ? '0 : userTask;

    kolibri_mmu_regfile #(
        .NP    (NP),
        .BW    (BW),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk     (MHZ48),
        .rst     (RES),
        .we      (pageWrite),
        .wAddr   (offset[IDX_W-1:0]),
        .wData   (BW'(D_IN[DW-1:0])),
        .mapAddr ({actTask, A[15:16-PAGE_BITS]}),
        .mapData (mapData),
        .rbAddr  (offset[IDX_W-1:0]),
        .rbData  (rbData)
    );

    assign MA      = mapEn ? mapData : '0;
    assign nMM     = ~mapEn;
    assign nSTROBE = ~(sel & E);
    assign D_OE    = sel & E & RW;

    always_comb begin
        D_OUT = '0;
        if (pageHit) begin
            D_OUT = 8'(rbData[DW-1:0]);
        end else if (offset == OFF_CTRL) begin
            D_OUT[CTRL_MAP_EN]   = mapEn;
            D_OUT[CTRL_AUTO_SYS] = autoSys;
        end else if (offset == OFF_TASK) begin
            D_OUT    = 8'(userTask);
            D_OUT[7] = SYS;
        end
    end

endmodule

// File: tb/tb_kolibri_mmu.sv
// tb/tb_kolibri_mmu.sv - self-checking bench for kolibri_mmu
module tb_kolibri_mmu;

    logic        clk = 1'b0;
    logic        RES = 1'b1;
    logic        E = 1'b0;
    logic [15:0] A = 16'h0000;
    logic        RW = 1'b1;
    logic [7:0]  D_IN = 8'h00;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        BA = 1'b0;
    logic        BS = 1'b0;
    logic        LIC = 1'b0;
    logic [7:0]  MA;
    logic        nMM;
    logic        nSTROBE;
    logic        SYS;

    kolibri_mmu dut (
        .MHZ48   (clk),
        .RES     (RES),
        .E       (E),
        .A       (A),
        .RW      (RW),
        .D_IN    (D_IN),
        .D_OUT   (D_OUT),
        .D_OE    (D_OE),
        .BA      (BA),
        .BS      (BS),
        .LIC     (LIC),
        .MA      (MA),
        .nMM     (nMM),
        .nSTROBE (nSTROBE),
        .SYS     (SYS)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] capMa, capDout;
    logic       capNmm, capSys, capOe, capStb;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    // One bus cycle: E low, E high for two clocks (outputs captured), E falls (commit).
    task automatic busCycle(input logic [15:0] a, input logic rw, input logic [7:0] din,
                            input logic ba, input logic bs, input logic lic);
        @(negedge clk);
        A = a; RW = rw; D_IN = din; BA = ba; BS = bs; LIC = lic; E = 1'b0;
        @(negedge clk);
        E = 1'b1;
        @(negedge clk);
        @(negedge clk);
        capMa = MA; capDout = D_OUT; capNmm = nMM; capSys = SYS;
        capOe = D_OE; capStb = nSTROBE;
        E = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  din;
        logic        ba, bs, lic;
        logic [7:0]  expMa;
        logic        expNmm, expSys, expOe, expStb;
        logic        chkRd;
        logic [7:0]  expDout;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] a, input logic rw, input logic [7:0] din,
                                input logic ba, input logic bs, input logic lic,
                                input logic [7:0] ma, input logic nmm, input logic sys,
                                input logic oe, input logic stb, input logic chk,
                                input logic [7:0] dout);
        vec_t v;
        v.a = a; v.rw = rw; v.din = din; v.ba = ba; v.bs = bs; v.lic = lic;
        v.expMa = ma; v.expNmm = nmm; v.expSys = sys; v.expOe = oe; v.expStb = stb;
        v.chkRd = chk; v.expDout = dout;
        return v;
    endfunction

    // Reference model: page contents, control bits, user task, and the two
    // facts "running the system task" and "return to user pending".
    logic [7:0] mPage [8];
    logic       mMapEn, mAutoSys, mTask, mInSys, mArmed;

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mPage[i] = 8'h00;
        mMapEn = 0; mAutoSys = 0; mTask = 0; mInSys = 1; mArmed = 0;
    endtask

    task automatic modelCycle(input int n, input logic [15:0] a, input logic rw,
                              input logic [7:0] din, input logic ba, input logic bs,
                              input logic lic);
        logic       hit;
        int         off, idx;
        logic [7:0] eMa, eDout;
        logic       vec, taskWr;
        hit = (a[15:4] == 12'hFE0);
        off = int'(a[3:0]);
        idx = ((mInSys ? 0 : int'(mTask)) * 4) + int'(a[15:14]);
        eMa = mMapEn ? mPage[idx] : 8'h00;
        if (off < 8) eDout = mPage[off];
        else if (off == 8) eDout = {6'd0, mAutoSys, mMapEn};
        else if (off == 9) eDout = {mInSys, 6'd0, mTask};
        else eDout = 8'h00;
        busCycle(a, rw, din, ba, bs, lic);
        check($sformatf("rnd%0d_ma", n), capMa, eMa);
        check($sformatf("rnd%0d_nmm", n), 8'(capNmm), 8'(!mMapEn));
        check($sformatf("rnd%0d_sys", n), 8'(capSys), 8'(mInSys));
        check($sformatf("rnd%0d_stb", n), 8'(capStb), 8'(!hit));
        check($sformatf("rnd%0d_oe", n), 8'(capOe), 8'(hit && rw));
        if (hit) check($sformatf("rnd%0d_dout", n), capDout, eDout);
        vec = mAutoSys && bs && !ba;
        taskWr = hit && !rw && off == 9;
        if (hit && !rw) begin
            if (off < 8) mPage[off] = din;
            else if (off == 8) begin mMapEn = din[0]; mAutoSys = din[1]; end
            else if (off == 9) mTask = din[0];
        end
        if (!mInSys) begin
            if (vec) begin mInSys = 1; mArmed = 0; end
        end else if (!mArmed) begin
            if (!vec && taskWr) mArmed = 1;
        end else begin
            if (vec) mArmed = 0;
            else if (lic) begin mInSys = 0; mArmed = 0; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [27];
        int   n;
        logic [15:0] ra;
        //            addr     rw  din    ba bs lic  ma    nmm sys oe stb chk dout
        tbl[0]  = mk(16'h8000, 1, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00);
        tbl[1]  = mk(16'hFE08, 0, 8'h01, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        tbl[2]  = mk(16'hFE00, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[3]  = mk(16'hFE01, 0, 8'h11, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[4]  = mk(16'hFE02, 0, 8'h12, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[5]  = mk(16'hFE03, 0, 8'h13, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[6]  = mk(16'hC123, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 0, 1, 0, 8'h00);
        tbl[7]  = mk(16'hFE02, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1, 8'h12);
        tbl[8]  = mk(16'hFE04, 0, 8'h20, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[9]  = mk(16'hFE05, 0, 8'h21, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[10] = mk(16'hFE06, 0, 8'h22, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[11] = mk(16'hFE07, 0, 8'h23, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[12] = mk(16'hFE08, 0, 8'h03, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[13] = mk(16'hFE09, 0, 8'h01, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[14] = mk(16'hFE09, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1, 8'h81);
        tbl[15] = mk(16'h4000, 1, 8'h00, 0, 0, 1, 8'h11, 0, 1, 0, 1, 0, 8'h00);
        tbl[16] = mk(16'h4000, 1, 8'h00, 0, 0, 0, 8'h21, 0, 0, 0, 1, 0, 8'h00);
        tbl[17] = mk(16'h4000, 1, 8'h00, 0, 1, 0, 8'h21, 0, 0, 0, 1, 0, 8'h00);
        tbl[18] = mk(16'h4000, 1, 8'h00, 0, 0, 0, 8'h11, 0, 1, 0, 1, 0, 8'h00);
        tbl[19] = mk(16'hFE09, 0, 8'h01, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[20] = mk(16'h4000, 1, 8'h00, 0, 1, 1, 8'h11, 0, 1, 0, 1, 0, 8'h00);
        tbl[21] = mk(16'hFE09, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1, 8'h81);
        tbl[22] = mk(16'h4000, 1, 8'h00, 0, 0, 1, 8'h11, 0, 1, 0, 1, 0, 8'h00);
        tbl[23] = mk(16'h4000, 1, 8'h00, 0, 0, 0, 8'h11, 0, 1, 0, 1, 0, 8'h00);
        tbl[24] = mk(16'hFE0F, 0, 8'hFF, 0, 0, 0, 8'h13, 0, 1, 0, 0, 0, 8'h00);
        tbl[25] = mk(16'hFE0F, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1, 8'h00);
        tbl[26] = mk(16'hFE08, 1, 8'h00, 0, 0, 0, 8'h13, 0, 1, 1, 0, 1, 8'h03);

        repeat (3) @(negedge clk);
        RES = 1'b0;

        for (int i = 0; i < 27; i++) begin
            busCycle(tbl[i].a, tbl[i].rw, tbl[i].din, tbl[i].ba, tbl[i].bs, tbl[i].lic);
            check($sformatf("vec%0d_ma", i), capMa, tbl[i].expMa);
            check($sformatf("vec%0d_nmm", i), 8'(capNmm), 8'(tbl[i].expNmm));
            check($sformatf("vec%0d_sys", i), 8'(capSys), 8'(tbl[i].expSys));
            check($sformatf("vec%0d_oe", i), 8'(capOe), 8'(tbl[i].expOe));
            check($sformatf("vec%0d_stb", i), 8'(capStb), 8'(tbl[i].expStb));
            if (tbl[i].chkRd) check($sformatf("vec%0d_dout", i), capDout, tbl[i].expDout);
        end

        // Write held with E high: nothing commits, then it turns into a read before E falls.
        @(negedge clk);
        A = 16'hFE00; RW = 1'b0; D_IN = 8'h55; E = 1'b1; BS = 1'b0; LIC = 1'b0;
        repeat (4) @(negedge clk);
        check("held_e_dout", D_OUT, 8'h10);
        RW = 1'b1;
        @(negedge clk);
        E = 1'b0;
        @(negedge clk);
        busCycle(16'hFE00, 1, 8'h00, 0, 0, 0);
        check("held_e_page0", capDout, 8'h10);

        // Reset in the middle of a page-register write.
        @(negedge clk);
        A = 16'hFE01; RW = 1'b0; D_IN = 8'h77; E = 1'b1;
        @(negedge clk);
        check("pre_reset_ma", MA, 8'h13);
        RES = 1'b1;
        #1;
        check("reset_ma", MA, 8'h00);
        check("reset_nmm", 8'(nMM), 8'h01);
        check("reset_sys", 8'(SYS), 8'h01);
        check("reset_oe", 8'(D_OE), 8'h00);
        @(negedge clk);
        E = 1'b0;
        @(negedge clk);
        RES = 1'b0;
        busCycle(16'hFE01, 1, 8'h00, 0, 0, 0);
        check("reset_page1", capDout, 8'h00);
        busCycle(16'hFE08, 1, 8'h00, 0, 0, 0);
        check("reset_ctrl", capDout, 8'h00);

        // Randomized traffic against the reference model, starting from reset state.
        modelReset();
        for (n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 1: ra = {12'hFE0, 4'($urandom_range(0, 9))};
                2:    ra = {12'hFE0, 4'($urandom_range(0, 15))};
                default: ra = 16'($urandom);
            endcase
            modelCycle(n, ra, 1'($urandom_range(0, 1)), 8'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
